cond_issue_ctrl: RTL and testbench

- Issue-stage controller for conditional execution.
- Owns the architectural NZCV status register and evaluates each decoded instruction's 4-bit condition field against it.
- Tracks in-flight flag-setting (S) instructions with a scoreboard counter and stalls conditional instructions until their flags are final.
- Sits between ID and EXE; EXE returns flag updates on a write port.

---
 rtl/cond_issue_ctrl_pkg.sv | 28 ++
 rtl/cond_issue_ctrl_eval.sv | 39 +++
 rtl/cond_issue_ctrl.sv | 87 ++++++++
 tb/tb_cond_issue_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cond_issue_ctrl_pkg.sv
// Shared definitions for the conditional-issue controller: condition codes and NZCV bit positions.
package cond_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_issue_ctrl_eval.sv
// Purely combinational condition evaluator: (cond, nzcv) -> pass.
module cond_eval
  import cond_issue_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  always_comb begin
    n      = nzcv_i[FLAG_N];
    z      = nzcv_i[FLAG_Z];
    c      = nzcv_i[FLAG_C];
    v      = nzcv_i[FLAG_V];
    pass_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_issue_ctrl.sv
// Issue-stage conditional-execution controller: NZCV register, flag scoreboard, stall logic.
// Optional macro FLAG_BYPASS_EN evaluates against the EXE write-back flags in the write cycle.
module cond_issue_ctrl
  import cond_issue_ctrl_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_cond,
  input  logic             id_s,
  output logic             id_ready,
  output logic             cond_pass,
  input  logic             upd_valid,
  input  logic [3:0]       upd_nzcv,
  input  logic             flush,
  output logic [3:0]       nzcv,
  output logic [CNT_W-1:0] pending,
  output logic             sb_err
);

  logic [3:0]       nzcv_q, nzcv_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             err_q, err_d;

  logic [3:0]       eval_flags;
  logic [CNT_W-1:0] pend_eff;
  logic             needs_flags, stall, issue, inc, dec;

`ifdef FLAG_BYPASS_EN
  // Last outstanding setter is writing back now: its flags are final, so use them directly.
  logic bypass;
  always_comb begin
    bypass     = upd_valid && (pend_q == CNT_W'(1));
    eval_flags = bypass ? upd_nzcv : nzcv_q;
    pend_eff   = bypass ? '0 : pend_q;
  end
`else
  always_comb begin
    eval_flags = nzcv_q;
    pend_eff   = pend_q;
  end
`endif

  cond_eval u_cond_eval (
    .cond_i (id_cond),
    .nzcv_i (eval_flags),
    .pass_o (cond_pass)
  );

  always_comb begin
    needs_flags = (id_cond != COND_AL) && (id_cond != COND_NV);
    stall       = id_valid &&
                  ((needs_flags && (pend_eff != '0)) ||
                   (id_s && cond_pass && (pend_eff == CNT_W'(MAX_INFLIGHT))));
    issue       = id_valid && !stall;
    inc         = issue && id_s && cond_pass;
    dec         = upd_valid && (pend_q != '0);
  end

  always_comb begin
    nzcv_d = upd_valid ? upd_nzcv : nzcv_q;
    err_d  = err_q || (upd_valid && (pend_q == '0));
    if (flush) pend_d = '0;
    else       pend_d = pend_q + CNT_W'(inc) - CNT_W'(dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      nzcv_q <= nzcv_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign id_ready = !stall;
  assign nzcv     = nzcv_q;
  assign pending  = pend_q;
  assign sb_err   = err_q;

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Scoreboard bench for cond_issue_ctrl: directed plan sequences, full condition sweep, random traffic.
module tb_cond_issue_ctrl;

  localparam int MAXI = 2;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [3:0]    id_cond = 4'h0;
  logic          id_s = 1'b0;
  logic          upd_valid = 1'b0;
  logic [3:0]    upd_nzcv = 4'h0;
  logic          flush = 1'b0;
  logic          id_ready, cond_pass, sb_err;
  logic [3:0]    nzcv;
  logic [CW-1:0] pending;

  cond_issue_ctrl #(.MAX_INFLIGHT(MAXI), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_cond   (id_cond),
    .id_s      (id_s),
    .id_ready  (id_ready),
    .cond_pass (cond_pass),
    .upd_valid (upd_valid),
    .upd_nzcv  (upd_nzcv),
    .flush     (flush),
    .nzcv      (nzcv),
    .pending   (pending),
    .sb_err    (sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       chk_pass;
    logic       ready;
    logic       pass;
    logic [3:0] nzcv;
    int         pend;
    logic       err;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference state: architectural flags, outstanding setter count, sticky error.
  int         m_cnt = 0;
  logic [3:0] m_nzcv = 4'h0;
  logic       m_err = 1'b0;

  // Conditions come in complementary pairs: cond[3:1] picks a base test, cond[0] inverts it.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("id_ready", int'(id_ready), int'(e.ready));
      if (e.chk_pass) check("cond_pass", int'(cond_pass), int'(e.pass));
      check("nzcv", int'(nzcv), int'(e.nzcv));
      check("pending", int'(pending), e.pend);
      check("sb_err", int'(sb_err), int'(e.err));
    end
  end

  task automatic step(input logic v, input logic [3:0] c, input logic s,
                      input logic u, input logic [3:0] un, input logic fl);
    exp_t e;
    logic [3:0] fe;
    int ec;
    logic byp, pass, needs, stall, inc, dec;
    @(posedge clk); #1;
    rst_n = 1'b1; id_valid = v; id_cond = c; id_s = s;
    upd_valid = u; upd_nzcv = un; flush = fl;
`ifdef FLAG_BYPASS_EN
    byp = u && (m_cnt == 1);
`else
    byp = 1'b0;
`endif
    fe    = byp ? un : m_nzcv;
    ec    = byp ? 0 : m_cnt;
    pass  = ref_cond(c, fe);
    needs = (c != 4'hE) && (c != 4'hF);
    stall = v && ((needs && ec != 0) || (s && pass && ec == MAXI));
    inc   = v && !stall && s && pass;
    dec   = u && (m_cnt != 0);
    e.chk_pass = v && !stall;
    e.ready = !stall; e.pass = pass;
    e.nzcv = m_nzcv; e.pend = m_cnt; e.err = m_err;
    q.push_back(e);
    if (u && m_cnt == 0) m_err = 1'b1;
    if (u) m_nzcv = un;
    m_cnt = fl ? 0 : m_cnt + int'(inc) - int'(dec);
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge clk); #1;
    rst_n = 1'b0; id_valid = 1'b0; id_cond = 4'h0; id_s = 1'b0;
    upd_valid = 1'b0; upd_nzcv = 4'h0; flush = 1'b0;
    m_cnt = 0; m_nzcv = 4'h0; m_err = 1'b0;
    e.chk_pass = 1'b0; e.ready = 1'b1; e.pass = 1'b0;
    e.nzcv = 4'h0; e.pend = 0; e.err = 1'b0;
    q.push_back(e);
  endtask

  initial begin
    do_reset();
    step(0, 4'h0, 0, 0, 4'h0, 0);
    // Error write with nothing pending, then EQ/NE against Z=1.
    step(0, 4'h0, 0, 1, 4'b0100, 0);
    step(1, 4'h0, 0, 0, 4'h0, 0);
    step(1, 4'h1, 0, 0, 4'h0, 0);
    // ADDS then dependent GE waiting on its flags.
    step(1, 4'hE, 1, 0, 4'h0, 0);
    step(1, 4'hA, 0, 0, 4'h0, 0);
    step(1, 4'hA, 0, 0, 4'h0, 0);
    step(1, 4'hA, 0, 1, 4'b1001, 0);
    step(1, 4'hA, 0, 0, 4'h0, 0);
    step(0, 4'h0, 0, 0, 4'h0, 0);
    // Saturation: three AL setters, third waits for a write-back.
    step(1, 4'hE, 1, 0, 4'h0, 0);
    step(1, 4'hE, 1, 0, 4'h0, 0);
    step(1, 4'hE, 1, 0, 4'h0, 0);
    step(1, 4'hE, 1, 0, 4'h0, 0);
    step(1, 4'hE, 1, 1, 4'b0011, 0);
    step(0, 4'h0, 0, 0, 4'h0, 0);
    // Flush with concurrent write-back.
    step(0, 4'h0, 0, 1, 4'b0010, 1);
    step(0, 4'h0, 0, 0, 4'h0, 0);
    // Failed conditional setter does not count.
    step(1, 4'h0, 1, 0, 4'h0, 0);
    step(0, 4'h0, 0, 0, 4'h0, 0);
    // Reset while a dependent instruction is stalled.
    step(1, 4'hE, 1, 0, 4'h0, 0);
    step(1, 4'h0, 0, 0, 4'h0, 0);
    do_reset();
    step(1, 4'h0, 0, 0, 4'h0, 0);
    // Full sweep of every condition against every flag value.
    for (int f = 0; f < 16; f++) begin
      step(0, 4'h0, 0, 1, 4'(f), 0);
      for (int c = 0; c < 16; c++) step(1, 4'(c), 0, 0, 4'h0, 0);
    end
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                4'($urandom_range(0, 15)), $urandom_range(0, 39) == 0);
    end
    step(0, 4'h0, 0, 0, 4'h0, 0);
    begin
      int budget = 10;
      while (q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (q.size() > 0) begin
        n_cmp++; n_err++;
        $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
